// File: rtl/edge_mask_tx.sv
// Edge-map transmitter: host loads the map as words, start streams it as slices over valid/ready.
// Optional macro EDGE_MASK_TX_PARITY_EN adds per-word even parity (tx_parity) on the current slice.
module edge_mask_tx #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned SLICE_W    = 128,
    parameter int unsigned NUM_SLICES = 32
) (
    input  logic                                         CLK,
    input  logic                                         RST_n,
    input  logic                                         wr_en,
    input  logic [$clog2(NUM_SLICES*SLICE_W/WORD_W)-1:0] wr_addr,
    input  logic [WORD_W-1:0]                            wr_data,
    input  logic                                         clr,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         tx_valid,
    input  logic                                         tx_ready,
    output logic [SLICE_W-1:0]                           edge_mask,
    output logic [$clog2(NUM_SLICES)-1:0]                data_sel,
    output logic                                         tx_last,
    output logic                                         done,
    output logic                                         wr_drop
`ifdef EDGE_MASK_TX_PARITY_EN
    ,
    output logic [SLICE_W/WORD_W-1:0]                    tx_parity
`endif
);

    localparam int unsigned WPS       = SLICE_W / WORD_W;
    localparam int unsigned NUM_WORDS = NUM_SLICES * WPS;
    localparam int unsigned ADDR_W    = $clog2(NUM_WORDS);
    localparam int unsigned SEL_W     = $clog2(NUM_SLICES);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t            state, state_d;
    logic [SEL_W-1:0]  sel_d;
    logic              valid_d, done_d, drop_d, busy_d, last_d;
    logic [WORD_W-1:0] mem [NUM_WORDS];

    logic host_ok;
    assign host_ok = (state == IDLE);

    // Buffer: writes and clear only land while idle, so a frame never sees a torn map.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) mem[i] <= '0;
        end else if (host_ok) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i))) mem[i] <= wr_data;
                else if (clr)                          mem[i] <= '0;
            end
        end
    end

    // Slice select driven by the registered index only.
    always_comb begin
        edge_mask = '0;
        for (int j = 0; j < int'(WPS); j++) begin
            edge_mask[j*WORD_W +: WORD_W] =
                mem[ADDR_W'(data_sel) * ADDR_W'(WPS) + ADDR_W'(j)];
        end
    end

`ifdef EDGE_MASK_TX_PARITY_EN
    always_comb begin
        tx_parity = '0;
        if (tx_valid) begin
            for (int j = 0; j < int'(WPS); j++) tx_parity[j] = ^edge_mask[j*WORD_W +: WORD_W];
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            data_sel <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            done     <= 1'b0;
            wr_drop  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            data_sel <= sel_d;
            tx_valid <= valid_d;
            tx_last  <= last_d;
            done     <= done_d;
            wr_drop  <= drop_d;
            busy     <= busy_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state;
        sel_d   = data_sel;
        valid_d = tx_valid;
        done_d  = 1'b0;
        drop_d  = !host_ok && (wr_en || clr);
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    sel_d   = '0;
                    valid_d = 1'b1;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (data_sel == LAST_SEL) begin
                        state_d = DONE;
                        sel_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = data_sel + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
        last_d = valid_d && (sel_d == LAST_SEL);
    end

endmodule
